multiplier_arbiter: RTL

- Shares one shift-add multiplier among NUM_REQ requesters using round-robin arbitration.
- Each requester presents a pair of operands. The arbiter latches the winner's operands, pulses start to the multiplier and times the fixed multiply latency.
- It then returns the product with a one-cycle done pulse to the winner.
- Sits between requesting blocks and the multiplier's start/multiplier/multiplicand/product interface.

---
 rtl/multiplier_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter that shares one fixed-latency multiplier among NUM_REQ
// requesters: latch the winner's operands, start the multiplier, wait, return the product.
module multiplier_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int OP_W        = 4,
    parameter int MUL_LATENCY = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*OP_W-1:0]      req_a,
    input  logic [NUM_REQ*OP_W-1:0]      req_b,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic                         rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [2*OP_W-1:0]            rsp_product,
    output logic                         busy,
    output logic                         mul_start,
    output logic [OP_W-1:0]              mul_multiplier,
    output logic [OP_W-1:0]              mul_multiplicand,
    input  logic [2*OP_W-1:0]            mul_product
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   id;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   idx;
    logic              found;
    logic [CNT_W-1:0]  counter;

    // First set request at or above ptr, wrapping; NUM_REQ is a power of two
    // so the index arithmetic wraps naturally.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        idx    = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + ID_W'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mul_start  = 1'b0;
        busy       = 1'b1;
        rsp_valid  = 1'b0;
        done       = '0;
        rsp_id     = '0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (found) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mul_start  = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (counter == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                rsp_valid  = 1'b1;
                done       = gnt;
                rsp_id     = id;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operands are captured once at acceptance; later requester activity
    // cannot disturb an operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr              <= '0;
            id               <= '0;
            counter          <= '0;
            gnt              <= '0;
            rsp_product      <= '0;
            mul_multiplier   <= '0;
            mul_multiplicand <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt              <= NUM_REQ'(1) << winner;
                        id               <= winner;
                        mul_multiplier   <= req_a[winner*OP_W +: OP_W];
                        mul_multiplicand <= req_b[winner*OP_W +: OP_W];
                    end
                end
                S_ISSUE: begin
                    counter <= CNT_W'(MUL_LATENCY - 1);
                end
                S_WAIT: begin
                    if (counter == '0) begin
                        rsp_product <= mul_product;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                S_DONE: begin
                    gnt <= '0;
                    ptr <= id + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
